// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction fields from ID, registered copies
// towards EX, and the pipeline control signals flush, hold and stall.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  // ID side
  logic             id_valid;
  logic             id_mem_rd;
  logic             id_mem_wr;
  logic             id_reg_wr;
  logic             id_mux_reg_wr;
  logic             id_mux_ula;
  logic             id_branch;
  logic [1:0]       id_ula_op;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic [2:0]       id_funct3;
  logic             id_funct7b5;
  // pipeline control
  logic             flush;
  logic             hold;
  logic             stall;
  // EX side
  logic             ex_valid;
  logic             ex_mem_rd;
  logic             ex_mem_wr;
  logic             ex_reg_wr;
  logic             ex_mux_reg_wr;
  logic             ex_mux_ula;
  logic             ex_branch;
  logic [1:0]       ex_ula_op;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1_data;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic [2:0]       ex_funct3;
  logic             ex_funct7b5;
  logic [CNT_W-1:0] bubble_cnt;

  // Driver of the ID fields and pipeline controls.
  modport master (
    output id_valid, id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_mux_ula,
           id_branch, id_ula_op, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5, flush, hold,
    input  stall, ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr,
           ex_mux_ula, ex_branch, ex_ula_op, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, bubble_cnt
  );

  // The pipeline register itself.
  modport slave (
    input  id_valid, id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_mux_ula,
           id_branch, id_ula_op, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5, flush, hold,
    output stall, ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr,
           ex_mux_ula, ex_branch, ex_ula_op, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold
// handling and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  logic rs2_used;
  logic hazard;
  logic bubble;
  logic load_ctrl;

  // Hazard detection and stall: the instruction in ID reads the register a
  // load in EX has not produced yet. rs1 is always compared, so U/J types
  // may stall spuriously; that costs one cycle and is harmless.
  always_comb begin
    rs2_used  = ~bus.id_mux_ula | bus.id_mem_wr | bus.id_branch;
    hazard    = bus.ex_valid & bus.ex_mem_rd & bus.id_valid & (bus.ex_rd != 5'd0) &
                ((bus.ex_rd == bus.id_rs1) | (rs2_used & (bus.ex_rd == bus.id_rs2)));
    bubble    = bus.flush | hazard;
    load_ctrl = ~bubble & bus.id_valid;
  end

  // NOTE: stall has no register on purpose -- it must freeze PC and IF/ID in
  // the same cycle the hazard appears, and a flush overrides it because the
  // stalled instruction is being killed anyway.
  assign bus.stall = bus.hold | (hazard & ~bus.flush);

  // Pipeline register: reset > hold > bubble (flush/hazard) > load.
  // NOTE: non-blocking assignments throughout, so every ex_* field updates
  // from the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_mem_rd     <= 1'b0;
      bus.ex_mem_wr     <= 1'b0;
      bus.ex_reg_wr     <= 1'b0;
      bus.ex_mux_reg_wr <= 1'b0;
      bus.ex_mux_ula    <= 1'b0;
      bus.ex_branch     <= 1'b0;
      bus.ex_ula_op     <= 2'b00;
      bus.ex_pc         <= '0;
      bus.ex_rs1_data   <= '0;
      bus.ex_rs2_data   <= '0;
      bus.ex_imm        <= '0;
      bus.ex_rs1        <= 5'd0;
      bus.ex_rs2        <= 5'd0;
      bus.ex_rd         <= 5'd0;
      bus.ex_funct3     <= 3'd0;
      bus.ex_funct7b5   <= 1'b0;
      bus.bubble_cnt    <= '0;
    end else if (!bus.hold) begin
      // Data and index fields always follow ID; in a bubble they are ignored
      // because ex_valid and the control bits are cleared.
      bus.ex_pc       <= bus.id_pc;
      bus.ex_rs1_data <= bus.id_rs1_data;
      bus.ex_rs2_data <= bus.id_rs2_data;
      bus.ex_imm      <= bus.id_imm;
      bus.ex_rs1      <= bus.id_rs1;
      bus.ex_rs2      <= bus.id_rs2;
      bus.ex_rd       <= bus.id_rd;
      bus.ex_funct3   <= bus.id_funct3;
      bus.ex_funct7b5 <= bus.id_funct7b5;

      // Control bits pass only for a real, non-bubbled instruction.
      bus.ex_valid      <= load_ctrl;
      bus.ex_mem_rd     <= load_ctrl & bus.id_mem_rd;
      bus.ex_mem_wr     <= load_ctrl & bus.id_mem_wr;
      bus.ex_reg_wr     <= load_ctrl & bus.id_reg_wr;
      bus.ex_mux_reg_wr <= load_ctrl & bus.id_mux_reg_wr;
      bus.ex_mux_ula    <= load_ctrl & bus.id_mux_ula;
      bus.ex_branch     <= load_ctrl & bus.id_branch;
      bus.ex_ula_op     <= load_ctrl ? bus.id_ula_op : 2'b00;

      if (bubble && (bus.bubble_cnt != {CNT_W{1'b1}}))
        bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued when the
// ID stimulus is driven and compared one clock later.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  // {mem_rd, mem_wr, reg_wr, mux_reg_wr, mux_ula, branch, ula_op[1:0]}
  localparam logic [7:0] C_LW   = 8'b1011_1000;
  localparam logic [7:0] C_ADD  = 8'b0010_0010;
  localparam logic [7:0] C_ADDI = 8'b0010_1010;
  localparam logic [7:0] C_ALU1 = 8'b0010_1001;
  localparam logic [7:0] C_NONE = 8'b0000_0000;

  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(16)) bus ();
  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(2))  sat_bus ();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bus));
  id_ex_stage #(.XLEN(XLEN), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(sat_bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic v, input logic [7:0] c, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.id_valid = v;
    {bus.id_mem_rd, bus.id_mem_wr, bus.id_reg_wr, bus.id_mux_reg_wr,
     bus.id_mux_ula, bus.id_branch, bus.id_ula_op} = c;
    bus.id_pc       = pc;
    bus.id_rs1_data = pc + 32'd1;
    bus.id_rs2_data = pc + 32'd2;
    bus.id_imm      = pc + 32'd3;
    bus.id_funct3   = pc[2:0];
    bus.id_funct7b5 = pc[3];
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
  endtask

  task automatic expect_ex(input logic v, input logic [7:0] c, input logic [31:0] pc,
                           input logic [4:0] rd, input logic [15:0] cnt);
    exp_t e;
    e.valid = v; e.ctrl = c; e.pc = pc; e.rd = rd; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic check_stall(input string tag, input logic exp);
    #1;
    check({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, exp});
  endtask

  // Clock once, then compare EX against the oldest queued expectation.
  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".valid"}, {31'd0, bus.ex_valid}, {31'd0, e.valid});
      check({tag, ".ctrl"}, {24'd0, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_reg_wr,
            bus.ex_mux_reg_wr, bus.ex_mux_ula, bus.ex_branch, bus.ex_ula_op},
            {24'd0, e.ctrl});
      check({tag, ".pc"}, bus.ex_pc, e.pc);
      check({tag, ".rd"}, {27'd0, bus.ex_rd}, {27'd0, e.rd});
      check({tag, ".cnt"}, {16'd0, bus.bubble_cnt}, {16'd0, e.cnt});
    end
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    apply(1'b0, C_NONE, 32'h0, 5'd0, 5'd0, 5'd0);
    sat_bus.flush = 1'b0; sat_bus.hold = 1'b0; sat_bus.id_valid = 1'b0;
    sat_bus.id_mem_rd = 1'b0; sat_bus.id_mem_wr = 1'b0; sat_bus.id_reg_wr = 1'b0;
    sat_bus.id_mux_reg_wr = 1'b0; sat_bus.id_mux_ula = 1'b0; sat_bus.id_branch = 1'b0;
    sat_bus.id_ula_op = 2'b00; sat_bus.id_pc = '0; sat_bus.id_rs1_data = '0;
    sat_bus.id_rs2_data = '0; sat_bus.id_imm = '0; sat_bus.id_rs1 = 5'd0;
    sat_bus.id_rs2 = 5'd0; sat_bus.id_rd = 5'd0; sat_bus.id_funct3 = 3'd0;
    sat_bus.id_funct7b5 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst.pc", bus.ex_pc, 32'd0);
    check("rst.rs1_data", bus.ex_rs1_data, 32'd0);
    check("rst.cnt", {16'd0, bus.bubble_cnt}, 32'd0);
    check("rst.stall", {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;

    // Plain flow
    apply(1'b1, C_ADD, 32'h100, 5'd1, 5'd2, 5'd5);
    check_stall("plain", 1'b0);
    expect_ex(1'b1, C_ADD, 32'h100, 5'd5, 16'd0);
    tick_check("plain");
    check("plain.imm", bus.ex_imm, 32'h103);

    // Load-use: lw x7, then add using x7 as rs2
    apply(1'b1, C_LW, 32'h104, 5'd1, 5'd0, 5'd7);
    check_stall("lw7", 1'b0);
    expect_ex(1'b1, C_LW, 32'h104, 5'd7, 16'd0);
    tick_check("lw7");
    apply(1'b1, C_ADD, 32'h108, 5'd3, 5'd7, 5'd8);
    check_stall("lu.haz", 1'b1);
    expect_ex(1'b0, C_NONE, 32'h108, 5'd8, 16'd1);
    tick_check("lu.bubble");
    check_stall("lu.clear", 1'b0);
    expect_ex(1'b1, C_ADD, 32'h108, 5'd8, 16'd1);
    tick_check("lu.add");

    // No false hazard: load to x0 followed by a reader of x0
    apply(1'b1, C_LW, 32'h10c, 5'd2, 5'd0, 5'd0);
    check_stall("lw0", 1'b0);
    expect_ex(1'b1, C_LW, 32'h10c, 5'd0, 16'd1);
    tick_check("lw0");
    apply(1'b1, C_ADD, 32'h110, 5'd0, 5'd0, 5'd9);
    check_stall("x0read", 1'b0);
    expect_ex(1'b1, C_ADD, 32'h110, 5'd9, 16'd1);
    tick_check("x0read");

    // No false hazard: addi does not use rs2
    apply(1'b1, C_LW, 32'h114, 5'd9, 5'd0, 5'd7);
    expect_ex(1'b1, C_LW, 32'h114, 5'd7, 16'd1);
    tick_check("lw7b");
    apply(1'b1, C_ADDI, 32'h118, 5'd4, 5'd7, 5'd10);
    check_stall("addi", 1'b0);
    expect_ex(1'b1, C_ADDI, 32'h118, 5'd10, 16'd1);
    tick_check("addi");

    // Flush together with a load-use hazard
    apply(1'b1, C_LW, 32'h11c, 5'd4, 5'd0, 5'd7);
    expect_ex(1'b1, C_LW, 32'h11c, 5'd7, 16'd1);
    tick_check("lw7c");
    apply(1'b1, C_ADD, 32'h120, 5'd1, 5'd7, 5'd11);
    bus.flush = 1'b1;
    check_stall("fl.haz", 1'b0);
    expect_ex(1'b0, C_NONE, 32'h120, 5'd11, 16'd2);
    tick_check("fl.haz");

    // Back-to-back flushes
    apply(1'b1, C_ADD, 32'h124, 5'd1, 5'd2, 5'd12);
    check_stall("fl2", 1'b0);
    expect_ex(1'b0, C_NONE, 32'h124, 5'd12, 16'd3);
    tick_check("fl2");
    apply(1'b1, C_ADD, 32'h128, 5'd1, 5'd2, 5'd13);
    expect_ex(1'b0, C_NONE, 32'h128, 5'd13, 16'd4);
    tick_check("fl3");
    bus.flush = 1'b0;

    // Hold for three cycles with changing ID and a flush pulse
    apply(1'b1, C_ALU1, 32'h130, 5'd1, 5'd2, 5'd14);
    expect_ex(1'b1, C_ALU1, 32'h130, 5'd14, 16'd4);
    tick_check("pre.hold");
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, C_LW, 32'h200 + 32'(i), 5'd3, 5'd3, 5'(20 + i));
      bus.flush = (i == 1);
      check_stall("hold", 1'b1);
      expect_ex(1'b1, C_ALU1, 32'h130, 5'd14, 16'd4);
      tick_check("hold");
    end
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    apply(1'b1, C_ADD, 32'h140, 5'd1, 5'd2, 5'd15);
    check_stall("post.hold", 1'b0);
    expect_ex(1'b1, C_ADD, 32'h140, 5'd15, 16'd4);
    tick_check("post.hold");

    // Invalid ID instruction: control forced low, not counted
    apply(1'b0, C_ADD, 32'h144, 5'd1, 5'd2, 5'd16);
    check_stall("inval", 1'b0);
    expect_ex(1'b0, C_NONE, 32'h144, 5'd16, 16'd4);
    tick_check("inval");

    // Reset during a stall
    apply(1'b1, C_LW, 32'h148, 5'd1, 5'd0, 5'd7);
    expect_ex(1'b1, C_LW, 32'h148, 5'd7, 16'd4);
    tick_check("lw7d");
    apply(1'b1, C_ADD, 32'h14c, 5'd7, 5'd2, 5'd17);
    check_stall("rst.haz", 1'b1);
    rst = 1'b1;
    expect_ex(1'b0, C_NONE, 32'h0, 5'd0, 16'd0);
    tick_check("rst.mid");
    check("rst.mid.rs2_data", bus.ex_rs2_data, 32'd0);
    check("rst.mid.stall", {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;

    // Saturation on the 2-bit counter instance
    sat_bus.flush = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat.cnt%0d", i), {30'd0, sat_bus.bubble_cnt},
            (i < 3) ? 32'(i) : 32'd3);
    end
    check("sat.valid", {31'd0, sat_bus.ex_valid}, 32'd0);
    sat_bus.flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
